pool_layer_param: RTL and testbench

Parametrised 2-D pooling engine. It is the generalised successor of the fixed 26x26 max-pool layer. It reads a CHANNELS x IN_H x IN_W feature map from a synchronous-read buffer and writes a CHANNELS x OUT_H x OUT_W pooled map to an output buffer. It supports max or average pooling, optional ReLU, configurable window/stride and data width. It sits between conv layer output buffers and the next conv/dense stage.

---
 rtl/pool_layer_param.sv | 260 ++++++++++++++++++++++++++
 tb/tb_pool_layer_param.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_layer_param.sv
// pool_layer_param: parametrised 2-D max/average pooling engine.
// Reads a CHANNELS x IN_H x IN_W map from a synchronous-read buffer and
// writes a CHANNELS x OUT_H x OUT_W pooled map, one window at a time.
//
// Handshake: start is sampled only while idle; the accepting edge latches
// pool_mode/relu_en, raises busy and clears done. busy stays high until the
// edge that raises done; done then stays high until the next accepted start
// or reset. start while busy is ignored. Each output pixel is presented for
// exactly one cycle with out_map_write_en high (no back-pressure).
module pool_layer_param #(
    parameter int DATA_W    = 16,
    parameter int IN_H      = 26,
    parameter int IN_W      = 26,
    parameter int CHANNELS  = 1,
    parameter int POOL_LOG2 = 1,
    localparam int P          = 1 << POOL_LOG2,
    localparam int OUT_H      = IN_H / P,
    localparam int OUT_W      = IN_W / P,
    localparam int IN_ADDR_W  = $clog2(CHANNELS * IN_H * IN_W),
    localparam int OUT_ADDR_W = $clog2(CHANNELS * OUT_H * OUT_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pool_mode,
    input  logic                     relu_en,
    output logic [IN_ADDR_W-1:0]     in_map_addr,
    input  logic signed [DATA_W-1:0] in_map_pixel,
    output logic [OUT_ADDR_W-1:0]    out_map_addr,
    output logic signed [DATA_W-1:0] out_map_pixel,
    output logic                     out_map_write_en,
    output logic                     busy,
    output logic                     done
);

    localparam int PP        = P * P;
    localparam int AVG_SHIFT = 2 * POOL_LOG2;
    localparam int ACC_W     = DATA_W + AVG_SHIFT;
    localparam int TAP_W     = 2 * POOL_LOG2 + 1;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    // FSM observation point: current state, window tap and the two
    // terminal-count flags that steer the state transitions.
    typedef struct packed {
        state_t             state;
        logic [TAP_W-1:0]   tap;
        logic               tap_last;
        logic               win_last;
    } fsm_dbg_t;

    state_t                   state_q;
    state_t                   state_d;
    fsm_dbg_t                 fsm_dbg;

    logic [TAP_W-1:0]         tap_q;
    logic [CNT_W-1:0]         ch_q;
    logic [CNT_W-1:0]         orow_q;
    logic [CNT_W-1:0]         ocol_q;
    logic [OUT_ADDR_W-1:0]    out_cnt_q;

    logic                     mode_q;
    logic                     relu_q;
    logic                     first_q;
    logic signed [ACC_W-1:0]  acc_q;

    logic [IN_ADDR_W-1:0]     in_addr_hold_q;
    logic [OUT_ADDR_W-1:0]    out_addr_hold_q;
    logic signed [DATA_W-1:0] out_pix_hold_q;

    logic                     accept;
    logic                     fetch_act;
    logic                     absorb;
    logic                     write_act;

    logic [TAP_W-1:0]         tap_row;
    logic [TAP_W-1:0]         tap_col;
    logic [IN_ADDR_W-1:0]     fetch_addr;
    logic signed [ACC_W-1:0]  px_ext;
    logic signed [DATA_W-1:0] pooled;
    logic signed [DATA_W-1:0] result;

    // Collect the FSM view used both by the control logic and by checkers.
    always_comb begin
        fsm_dbg          = '0;
        fsm_dbg.state    = state_q;
        fsm_dbg.tap      = tap_q;
        fsm_dbg.tap_last = (tap_q == TAP_W'(PP - 1));
        fsm_dbg.win_last = (ch_q   == CNT_W'(CHANNELS - 1)) &&
                           (orow_q == CNT_W'(OUT_H - 1)) &&
                           (ocol_q == CNT_W'(OUT_W - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        fetch_act = 1'b0;
        absorb    = 1'b0;
        write_act = 1'b0;
        case (fsm_dbg.state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                fetch_act = 1'b1;
                // Tap 0's data only arrives next cycle, so nothing to absorb yet.
                absorb    = (fsm_dbg.tap != '0);
                if (fsm_dbg.tap_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                absorb  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                write_act = 1'b1;
                state_d   = fsm_dbg.win_last ? FIN : FETCH;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Input address of the current tap: channel-major, then row-major.
    always_comb begin
        tap_row    = fsm_dbg.tap >> POOL_LOG2;
        tap_col    = fsm_dbg.tap & TAP_W'(P - 1);
        fetch_addr = IN_ADDR_W'(32'(ch_q) * (IN_H * IN_W)
                              + (32'(orow_q) * P + 32'(tap_row)) * IN_W
                              + 32'(ocol_q) * P + 32'(tap_col));
    end

    // Window scan counters: tap inside the window, then column, row, channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q     <= '0;
            ch_q      <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            out_cnt_q <= '0;
        end else if (accept) begin
            tap_q     <= '0;
            ch_q      <= '0;
            orow_q    <= '0;
            ocol_q    <= '0;
            out_cnt_q <= '0;
        end else if (fetch_act) begin
            tap_q <= fsm_dbg.tap_last ? '0 : tap_q + TAP_W'(1);
        end else if (write_act) begin
            out_cnt_q <= out_cnt_q + OUT_ADDR_W'(1);
            if (ocol_q == CNT_W'(OUT_W - 1)) begin
                ocol_q <= '0;
                if (orow_q == CNT_W'(OUT_H - 1)) begin
                    orow_q <= '0;
                    ch_q   <= ch_q + CNT_W'(1);
                end else begin
                    orow_q <= orow_q + CNT_W'(1);
                end
            end else begin
                ocol_q <= ocol_q + CNT_W'(1);
            end
        end
    end

    // Sign-extend the returned pixel to the accumulator width.
    assign px_ext = ACC_W'(in_map_pixel);

    // Accumulator: first sample of a window loads directly, later samples
    // either add (average) or replace on a strictly greater value (max).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            first_q <= 1'b0;
        end else if (accept || write_act) begin
            first_q <= 1'b1;
        end else if (absorb) begin
            first_q <= 1'b0;
            if (first_q) begin
                acc_q <= px_ext;
            end else if (mode_q) begin
                acc_q <= acc_q + px_ext;
            end else if (px_ext > acc_q) begin
                acc_q <= px_ext;
            end
        end
    end

    // Pooled value: the arithmetic shift floors toward minus infinity and the
    // mean always fits DATA_W, so the truncation is exact. ReLU comes last.
    always_comb begin
        pooled = mode_q ? DATA_W'(acc_q >>> AVG_SHIFT) : acc_q[DATA_W-1:0];
        result = (relu_q && pooled[DATA_W-1]) ? '0 : pooled;
    end

    // Hold registers keep the last driven address/pixel between active states.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_addr_hold_q  <= '0;
            out_addr_hold_q <= '0;
            out_pix_hold_q  <= '0;
        end else begin
            if (fetch_act) begin
                in_addr_hold_q <= fetch_addr;
            end
            if (write_act) begin
                out_addr_hold_q <= out_cnt_q;
                out_pix_hold_q  <= result;
            end
        end
    end

    // Pass status and the mode bits frozen for the duration of a pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            mode_q <= 1'b0;
            relu_q <= 1'b0;
        end else if (accept) begin
            busy   <= 1'b1;
            done   <= 1'b0;
            mode_q <= pool_mode;
            relu_q <= relu_en;
        end else if (fsm_dbg.state == FIN) begin
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

    assign in_map_addr      = fetch_act ? fetch_addr : in_addr_hold_q;
    assign out_map_write_en = write_act;
    assign out_map_addr     = write_act ? out_cnt_q : out_addr_hold_q;
    assign out_map_pixel    = write_act ? result : out_pix_hold_q;

endmodule

// File: tb/tb_pool_layer_param.sv
// Bench for pool_layer_param: three instances (default 26x26/P=2,
// two-channel 5x5/P=2, 8x8/P=4) sharing one behavioural input buffer.
module tb_pool_layer_param;

    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       pool_mode;
    logic       relu_en;
    logic [2:0] start_v;

    // Input buffer contents, shared by whichever instance is running.
    int mem [0:675];

    // Instance 0: defaults.
    logic [9:0]           ia0;
    logic [7:0]           oa0;
    logic signed [DW-1:0] ip0, op0;
    logic                 we0, busy0, done0;
    pool_layer_param u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .pool_mode(pool_mode),
        .relu_en(relu_en), .in_map_addr(ia0), .in_map_pixel(ip0),
        .out_map_addr(oa0), .out_map_pixel(op0), .out_map_write_en(we0),
        .busy(busy0), .done(done0));
    always @(posedge clk) ip0 <= DW'(mem[ia0]);

    // Instance 1: two channels of 5x5 (odd size).
    logic [5:0]           ia1;
    logic [2:0]           oa1;
    logic signed [DW-1:0] ip1, op1;
    logic                 we1, busy1, done1;
    pool_layer_param #(.IN_H(5), .IN_W(5), .CHANNELS(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .pool_mode(pool_mode),
        .relu_en(relu_en), .in_map_addr(ia1), .in_map_pixel(ip1),
        .out_map_addr(oa1), .out_map_pixel(op1), .out_map_write_en(we1),
        .busy(busy1), .done(done1));
    always @(posedge clk) ip1 <= DW'(mem[ia1]);

    // Instance 2: 8x8 with a 4x4 window.
    logic [5:0]           ia2;
    logic [1:0]           oa2;
    logic signed [DW-1:0] ip2, op2;
    logic                 we2, busy2, done2;
    pool_layer_param #(.IN_H(8), .IN_W(8), .POOL_LOG2(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .pool_mode(pool_mode),
        .relu_en(relu_en), .in_map_addr(ia2), .in_map_pixel(ip2),
        .out_map_addr(oa2), .out_map_pixel(op2), .out_map_write_en(we2),
        .busy(busy2), .done(done2));
    always @(posedge clk) ip2 <= DW'(mem[ia2]);

    // Configuration of the instance under test.
    int sel;
    int cfg_c [3] = '{1, 2, 1};
    int cfg_h [3] = '{26, 5, 8};
    int cfg_w [3] = '{26, 5, 8};
    int cfg_l [3] = '{1, 1, 2};

    int                   cur_ia, cur_oa;
    logic signed [DW-1:0] cur_op;
    logic                 cur_we, cur_busy, cur_done;
    always_comb begin
        cur_ia = int'(ia0); cur_oa = int'(oa0); cur_op = op0;
        cur_we = we0; cur_busy = busy0; cur_done = done0;
        case (sel)
            1: begin
                cur_ia = int'(ia1); cur_oa = int'(oa1); cur_op = op1;
                cur_we = we1; cur_busy = busy1; cur_done = done1;
            end
            2: begin
                cur_ia = int'(ia2); cur_oa = int'(oa2); cur_op = op2;
                cur_we = we2; cur_busy = busy2; cur_done = done2;
            end
            default: ;
        endcase
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            exp_rd_q[$];
    int            out_arr [0:255];
    int            rd_log[$];
    int            wr_cnt;
    int            order_err;
    bit            log_en;
    int            n_checks;
    int            n_fail;

    // Capture write pulses and the sequence of distinct read addresses.
    always @(negedge clk) begin
        if (log_en) begin
            if (cur_we) begin
                if (cur_oa != wr_cnt) order_err++;
                if (cur_oa < 256) out_arr[cur_oa] = int'(cur_op);
                wr_cnt++;
            end
            if (cur_busy && (rd_log.size() == 0 || cur_ia != rd_log[$]))
                rd_log.push_back(cur_ia);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " in_map_addr"}, cur_ia, 0);
        check({tag, " out_map_addr"}, cur_oa, 0);
        check({tag, " out_map_pixel"}, int'(cur_op), 0);
        check({tag, " write_en"}, int'(cur_we), 0);
        check({tag, " busy"}, int'(cur_busy), 0);
        check({tag, " done"}, int'(cur_done), 0);
    endtask

    // Reference model: walk every window in order, reduce with plain integer
    // arithmetic (max, or floor of the true mean), then apply ReLU.
    function automatic void build_exp(input bit mode, input bit relu);
        int p, oh, ow, a, v, best, sum, q, res;
        p  = 1 << cfg_l[sel];
        oh = cfg_h[sel] / p;
        ow = cfg_w[sel] / p;
        exp_q.delete();
        exp_rd_q.delete();
        for (int c = 0; c < cfg_c[sel]; c++)
            for (int r = 0; r < oh; r++)
                for (int k = 0; k < ow; k++) begin
                    best = -(1 << 30);
                    sum  = 0;
                    for (int i = 0; i < p; i++)
                        for (int j = 0; j < p; j++) begin
                            a = c * cfg_h[sel] * cfg_w[sel] + (r * p + i) * cfg_w[sel] + k * p + j;
                            exp_rd_q.push_back(a);
                            v = mem[a];
                            sum += v;
                            if (v > best) best = v;
                        end
                    if (mode) begin
                        q = sum / (p * p);
                        if ((sum % (p * p)) != 0 && sum < 0) q = q - 1;
                        res = q;
                    end else begin
                        res = best;
                    end
                    if (relu && res < 0) res = 0;
                    exp_q.push_back(DW'(res));
                end
    endfunction

    // Drive one pass; returns the cycle (counted from the accepting edge) in
    // which done was first seen high, or in which the reset check ran.
    task automatic run_pass(input bit mode, input bit relu, input int poke,
                            input int rst_at, input bit flip, output int cyc);
        wr_cnt    = 0;
        order_err = 0;
        rd_log.delete();
        for (int i = 0; i < 256; i++) out_arr[i] = -99999;
        @(negedge clk);
        pool_mode = mode;
        relu_en   = relu;
        start_v   = 3'(1 << sel);
        log_en    = 1'b1;
        @(posedge clk);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start_v = '0;
                check("busy after start", int'(cur_busy), 1);
                check("done cleared by start", int'(cur_done), 0);
            end
            if (poke != 0 && cyc == poke) start_v = 3'(1 << sel);
            if (poke != 0 && cyc == poke + 1) start_v = '0;
            if (flip && cyc == 5) begin
                pool_mode = ~mode;
                relu_en   = ~relu;
            end
            if (rst_at != 0 && cyc == rst_at) reset = 1'b1;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                reset = 1'b0;
                check_zero("after mid-pass reset");
                break;
            end
            if (cur_done) break;
            if (cyc > 5000) begin
                n_checks++;
                n_fail++;
                $display("FAIL done timeout: got no done after %0d cycles, expected done", cyc);
                break;
            end
        end
        log_en = 1'b0;
    endtask

    // Compare a finished pass against the reference model.
    task automatic verify(input int cyc, input bit mode, input bit relu);
        int n, pp, mism, sz;
        build_exp(mode, relu);
        n  = exp_q.size();
        pp = (1 << cfg_l[sel]) * (1 << cfg_l[sel]);
        check("write count", wr_cnt, n);
        check("write address order", order_err, 0);
        for (int i = 0; i < n; i++)
            check($sformatf("out[%0d]", i), out_arr[i], int'($signed(exp_q.pop_front())));
        check("done cycle", cyc, n * (pp + 2) + 2);
        check("busy low at done", int'(cur_busy), 0);
        check("done level", int'(cur_done), 1);
        sz = exp_rd_q.size();
        check("read count", rd_log.size(), sz);
        mism = 0;
        for (int i = 0; i < sz && i < rd_log.size(); i++)
            if (rd_log[i] != exp_rd_q[i]) mism++;
        check("read sequence mismatches", mism, 0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) mem[i] = int'($urandom_range(65535)) - 32768;
    endtask

    // ---------------- table vectors for window 0 ----------------
    typedef struct {
        bit mode;
        bit relu;
        int v0, v1, v2, v3;
        int exp0;
        int exp1;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cyc, bad;
        bit m, r;

        tbl[0] = '{1'b0, 1'b0, 10, 20, 30, 100, 100, 29};
        tbl[1] = '{1'b1, 1'b0, 10, 20, 30, 100, 40, 15};
        tbl[2] = '{1'b0, 1'b1, 10, 20, 30, 100, 100, 29};
        tbl[3] = '{1'b0, 1'b0, -5, -3, -8, -1, -1, 29};
        tbl[4] = '{1'b0, 1'b1, -5, -3, -8, -1, 0, 29};
        tbl[5] = '{1'b1, 1'b0, -5, -3, -8, -1, -5, 15};
        tbl[6] = '{1'b1, 1'b1, -5, -3, -8, -1, 0, 15};

        n_checks  = 0;
        n_fail    = 0;
        log_en    = 1'b0;
        sel       = 0;
        reset     = 1'b1;
        start_v   = '0;
        pool_mode = 1'b0;
        relu_en   = 1'b0;
        for (int i = 0; i < 676; i++) mem[i] = 0;
        repeat (3) @(negedge clk);
        check_zero("reset state");
        reset = 1'b0;

        // Default instance: table of window-0 patterns over input[i] = i % 50.
        // The first vector also re-pulses start mid-pass.
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < 676; i++) mem[i] = i % 50;
            mem[0]  = tbl[t].v0;
            mem[1]  = tbl[t].v1;
            mem[26] = tbl[t].v2;
            mem[27] = tbl[t].v3;
            run_pass(tbl[t].mode, tbl[t].relu, (t == 0) ? 100 : 0, 0, 1'b0, cyc);
            check($sformatf("vec%0d out[0]", t), out_arr[0], tbl[t].exp0);
            check($sformatf("vec%0d out[1]", t), out_arr[1], tbl[t].exp1);
            verify(cyc, tbl[t].mode, tbl[t].relu);
        end

        // Reset in the middle of a pass, then a full pass afterwards.
        fill_random(676);
        run_pass(1'b1, 1'b0, 0, 300, 1'b0, cyc);
        check("reset abort cycle", cyc, 301);
        run_pass(1'b1, 1'b0, 0, 0, 1'b0, cyc);
        verify(cyc, 1'b1, 1'b0);

        // Random data and modes, with the mode inputs toggled mid-pass.
        for (int k = 0; k < 2; k++) begin
            fill_random(676);
            m = 1'($urandom_range(1));
            r = 1'($urandom_range(1));
            run_pass(m, r, 0, 0, 1'b1, cyc);
            verify(cyc, m, r);
        end

        // Two channels of 5x5: trailing row/column never read.
        sel = 1;
        for (int k = 0; k < 2; k++) begin
            fill_random(50);
            m = 1'(k);
            r = 1'($urandom_range(1));
            run_pass(m, r, 0, 0, 1'(k), cyc);
            check("5x5 done cycle", cyc, 50);
            if (rd_log.size() > 16) check("channel 1 first read", rd_log[16], 25);
            else check("channel 1 read log length", rd_log.size(), 32);
            bad = 0;
            foreach (rd_log[i])
                if ((rd_log[i] % 25) / 5 == 4 || rd_log[i] % 5 == 4) bad++;
            check("reads touching row 4 or col 4", bad, 0);
            verify(cyc, m, r);
        end

        // 8x8 with a 4x4 window, input = index.
        sel = 2;
        for (int i = 0; i < 64; i++) mem[i] = i;
        run_pass(1'b0, 1'b0, 0, 0, 1'b0, cyc);
        check("8x8 out[0]", out_arr[0], 27);
        check("8x8 out[1]", out_arr[1], 31);
        check("8x8 out[2]", out_arr[2], 59);
        check("8x8 out[3]", out_arr[3], 63);
        check("8x8 done cycle", cyc, 74);
        verify(cyc, 1'b0, 1'b0);
        fill_random(64);
        run_pass(1'b1, 1'b1, 0, 0, 1'b1, cyc);
        verify(cyc, 1'b1, 1'b1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
